// File: rtl/usb_pkg.sv
// Shared USB receive definitions: line-state codes, rx FSM states and framing constants.
package usb_pkg;

  typedef enum logic [1:0] {
    LS_SE0 = 2'b00,
    LS_J   = 2'b01,
    LS_K   = 2'b10,
    LS_SE1 = 2'b11
  } line_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_SYNC,
    RX_DATA,
    RX_EOP,
    RX_ERR
  } rx_state_t;

  localparam int STUFF_RUN      = 6;
  localparam int SYNC_MIN_ALT   = 3;
  localparam int IDLE_J_TIMEOUT = 8;

  // Low-speed swaps which differential polarity counts as J.
  function automatic line_t decode_line(input logic plus, input logic minus, input logic low_speed);
    if (plus == minus) return plus ? LS_SE1 : LS_SE0;
    return (plus ^ low_speed) ? LS_J : LS_K;
  endfunction

endpackage

// File: rtl/usb_rx_dpll.sv
// Line synchroniser and bit-clock recovery: 2-flop sync, registered line state, phase counter.
// Latency: line to line_state 3 clk; sample_stb lands OVERSAMPLE/2 clk after each J/K edge.
// No backpressure: free-running, keeps tracking the line regardless of downstream state.
module usb_rx_dpll #(
  parameter int OVERSAMPLE = 4,
  parameter bit LOW_SPEED  = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_plus,
  input  logic       rx_minus,
  output logic [1:0] line_state,
  output logic       sample_stb
);
  import usb_pkg::*;

  localparam int PW = $clog2(OVERSAMPLE);
  localparam logic J_PLUS = !LOW_SPEED;

  logic [1:0]    plus_sync;
  logic [1:0]    minus_sync;
  logic [PW-1:0] phase;
  line_t         ls_q;
  line_t         ls_next;
  logic          jk_edge;

  assign ls_next = decode_line(plus_sync[1], minus_sync[1], LOW_SPEED);
  // Only J<->K edges carry timing; SE0/SE1 excursions leave the phase free-running.
  assign jk_edge = ((ls_next == LS_J) && (ls_q == LS_K)) ||
                   ((ls_next == LS_K) && (ls_q == LS_J));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      plus_sync  <= {2{J_PLUS}};
      minus_sync <= {2{!J_PLUS}};
      ls_q       <= LS_J;
      phase      <= '0;
    end else begin
      plus_sync  <= {plus_sync[0], rx_plus};
      minus_sync <= {minus_sync[0], rx_minus};
      ls_q       <= ls_next;
      if (jk_edge || (phase == PW'(OVERSAMPLE - 1))) phase <= '0;
      else                                           phase <= phase + 1'b1;
    end
  end

  assign line_state = ls_q;
  assign sample_stb = (phase == PW'(OVERSAMPLE / 2));

endmodule

// File: rtl/usb_fs_rx_phy.sv
// Upstream-port USB receiver: NRZI decode, SYNC/EOP framing, bit unstuffing and byte assembly.
// Latency: line to line_state 3 clk; rx_valid/rx_error 1 clk after the deciding sample strobe.
// No backpressure: rx_valid is a one-cycle strobe; rx_enable=0 aborts to IDLE without output.
module usb_fs_rx_phy #(
  parameter int OVERSAMPLE = 4,
  parameter bit LOW_SPEED  = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_plus,
  input  logic       rx_minus,
  input  logic       rx_enable,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_active,
  output logic       rx_error,
  output logic [1:0] line_state
);
  import usb_pkg::*;

  logic       sample_stb;
  rx_state_t  state;
  line_t      prev_sym;
  line_t      sym;
  logic [2:0] alt_cnt;
  logic [2:0] ones_run;
  logic [2:0] bit_cnt;
  logic [2:0] j_cnt;
  logic [6:0] shift;
  logic       se0_seen;
  logic       is_jk;
  logic       nrzi_bit;
  logic       se1_err;
  logic       stuff_err;

  usb_rx_dpll #(
    .OVERSAMPLE (OVERSAMPLE),
    .LOW_SPEED  (LOW_SPEED)
  ) u_dpll (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_plus    (rx_plus),
    .rx_minus   (rx_minus),
    .line_state (line_state),
    .sample_stb (sample_stb)
  );

  assign sym       = line_t'(line_state);
  assign is_jk     = (sym == LS_J) || (sym == LS_K);
  assign nrzi_bit  = (sym == prev_sym);
  assign se1_err   = (sym == LS_SE1) && (state inside {RX_SYNC, RX_DATA, RX_EOP});
  assign stuff_err = (state == RX_DATA) && is_jk && (ones_run == 3'(STUFF_RUN)) && nrzi_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RX_IDLE;
      prev_sym  <= LS_J;
      alt_cnt   <= '0;
      ones_run  <= '0;
      bit_cnt   <= '0;
      j_cnt     <= '0;
      shift     <= '0;
      se0_seen  <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_active <= 1'b0;
      rx_error  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
      if (!rx_enable) begin
        state     <= RX_IDLE;
        rx_active <= 1'b0;
        prev_sym  <= LS_J;
      end else if (sample_stb && (se1_err || stuff_err)) begin
        state    <= RX_ERR;
        rx_error <= 1'b1;
        se0_seen <= 1'b0;
        j_cnt    <= '0;
      end else if (sample_stb) begin
        case (state)
          RX_IDLE: if (sym == LS_K) begin
            state    <= RX_SYNC;
            prev_sym <= LS_K;
            alt_cnt  <= '0;
          end
          RX_SYNC: begin
            if (!is_jk) begin
              state    <= RX_IDLE;
              prev_sym <= LS_J;
            end else if (sym == prev_sym) begin
              // KK closes SYNC; the trailing K is the NRZI reference for bit 0.
              if ((sym == LS_K) && (alt_cnt >= 3'(SYNC_MIN_ALT))) begin
                state     <= RX_DATA;
                rx_active <= 1'b1;
                ones_run  <= '0;
                bit_cnt   <= '0;
              end else begin
                state    <= RX_IDLE;
                prev_sym <= LS_J;
              end
            end else begin
              prev_sym <= sym;
              if (alt_cnt != 3'd7) alt_cnt <= alt_cnt + 3'd1;
            end
          end
          RX_DATA: begin
            if (sym == LS_SE0) begin
              state <= RX_EOP;
              if (bit_cnt != 3'd0) rx_error <= 1'b1;
            end else begin
              prev_sym <= sym;
              if (ones_run == 3'(STUFF_RUN)) begin
                ones_run <= '0;
              end else begin
                shift    <= {nrzi_bit, shift[6:1]};
                bit_cnt  <= bit_cnt + 3'd1;
                ones_run <= nrzi_bit ? ones_run + 3'd1 : 3'd0;
                if (bit_cnt == 3'd7) begin
                  rx_data  <= {nrzi_bit, shift};
                  rx_valid <= 1'b1;
                end
              end
            end
          end
          RX_EOP: if (sym == LS_J) begin
            state     <= RX_IDLE;
            rx_active <= 1'b0;
            prev_sym  <= LS_J;
          end
          RX_ERR: begin
            if (sym == LS_SE0) begin
              se0_seen <= 1'b1;
              j_cnt    <= '0;
            end else if (sym == LS_J) begin
              if (se0_seen || (j_cnt == 3'(IDLE_J_TIMEOUT - 1))) begin
                state     <= RX_IDLE;
                rx_active <= 1'b0;
                prev_sym  <= LS_J;
              end else begin
                j_cnt <= j_cnt + 3'd1;
              end
            end else begin
              j_cnt <= '0;
            end
          end
          default: begin
            state    <= RX_IDLE;
            prev_sym <= LS_J;
          end
        endcase
      end
    end
  end

endmodule
